// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write-port bundle for imem_loader.
// Optional checksum outputs exist only when IMEM_LOADER_CHECKSUM_EN is defined.
interface imem_loader_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 i_Start;
  logic [31:0]          i_BaseAddr;
  logic [CNT_WIDTH-1:0] i_WordCount;
  logic                 i_ByteValid;
  logic [7:0]           i_Byte;
  logic                 o_ByteReady;
  logic                 o_WrEn;
  logic [31:0]          o_WrAddr;
  logic [31:0]          o_WrData;
  logic                 o_Busy;
  logic                 o_Done;
  logic                 o_Overflow;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]          o_Checksum;
  logic                 o_ChkErr;

  modport master (
    output i_Start, i_BaseAddr, i_WordCount, i_ByteValid, i_Byte,
    input  o_ByteReady, o_WrEn, o_WrAddr, o_WrData, o_Busy, o_Done, o_Overflow,
    input  o_Checksum, o_ChkErr
  );

  modport slave (
    input  i_Start, i_BaseAddr, i_WordCount, i_ByteValid, i_Byte,
    output o_ByteReady, o_WrEn, o_WrAddr, o_WrData, o_Busy, o_Done, o_Overflow,
    output o_Checksum, o_ChkErr
  );
`else
  modport master (
    output i_Start, i_BaseAddr, i_WordCount, i_ByteValid, i_Byte,
    input  o_ByteReady, o_WrEn, o_WrAddr, o_WrData, o_Busy, o_Done, o_Overflow
  );

  modport slave (
    input  i_Start, i_BaseAddr, i_WordCount, i_ByteValid, i_Byte,
    output o_ByteReady, o_WrEn, o_WrAddr, o_WrData, o_Busy, o_Done, o_Overflow
  );
`endif
endinterface

// File: rtl/imem_loader.sv
// Assembles a little-endian byte stream into 32-bit words and writes them into
// instruction memory. Optional trailing checksum word: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH_WORDS = 64,
  parameter int CNT_WIDTH   = 16
) (
  input logic          i_Clk,
  input logic          i_Reset,
  imem_loader_if.slave bus
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, CHECK, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DONE} state_t;
`endif

  localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);

  state_t               state_q;
  logic [1:0]           idx_q;
  logic [23:0]          word_q;
  logic [31:0]          addr_q;
  logic [CNT_WIDTH-1:0] rem_q;
  logic                 rdy_q;
  logic                 wren_q;
  logic [31:0]          wraddr_q;
  logic [31:0]          wrdata_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 ovf_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]          chk_q;
  logic                 chkerr_q;
`endif

  logic        accept;
  logic        in_range;
  logic [31:0] full_word;
  logic        base_lsb_unused;

  assign accept          = rdy_q & bus.i_ByteValid;
  assign in_range        = ({1'b0, addr_q} < ADDR_LIMIT);
  assign full_word       = {bus.i_Byte, word_q};
  assign base_lsb_unused = ^bus.i_BaseAddr[1:0];

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      word_q   <= '0;
      addr_q   <= '0;
      rem_q    <= '0;
      rdy_q    <= 1'b0;
      wren_q   <= 1'b0;
      wraddr_q <= '0;
      wrdata_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q    <= '0;
      chkerr_q <= 1'b0;
`endif
    end else begin
      wren_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.i_Start) begin
            addr_q <= {bus.i_BaseAddr[31:2], 2'b00};
            rem_q  <= bus.i_WordCount;
            ovf_q  <= 1'b0;
            idx_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q    <= '0;
            chkerr_q <= 1'b0;
`endif
            if (bus.i_WordCount == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_q <= CHECK;
              rdy_q   <= 1'b1;
              busy_q  <= 1'b1;
`else
              state_q <= DONE;
              done_q  <= 1'b1;
`endif
            end else begin
              state_q <= COLLECT;
              rdy_q   <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end

        COLLECT: begin
          if (accept) begin
            // The range decision is made here so o_WrEn is a registered output
            // that is already valid in the WRITE cycle.
            if (idx_q == 2'd3) begin
              state_q  <= WRITE;
              rdy_q    <= 1'b0;
              wren_q   <= in_range;
              wraddr_q <= addr_q;
              wrdata_q <= full_word;
            end else begin
              case (idx_q)
                2'd0:    word_q[7:0]   <= bus.i_Byte;
                2'd1:    word_q[15:8]  <= bus.i_Byte;
                default: word_q[23:16] <= bus.i_Byte;
              endcase
              idx_q <= idx_q + 2'd1;
            end
          end
        end

        WRITE: begin
          idx_q <= '0;
          if (!in_range) begin
            ovf_q   <= 1'b1;
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            addr_q <= addr_q + 32'd4;
            rem_q  <= rem_q - CNT_WIDTH'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q  <= chk_q ^ wrdata_q;
`endif
            if (rem_q == CNT_WIDTH'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_q <= CHECK;
              rdy_q   <= 1'b1;
`else
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
`endif
            end else begin
              state_q <= COLLECT;
              rdy_q   <= 1'b1;
            end
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (accept) begin
            if (idx_q == 2'd3) begin
              if (full_word != chk_q) chkerr_q <= 1'b1;
              state_q <= DONE;
              rdy_q   <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              case (idx_q)
                2'd0:    word_q[7:0]   <= bus.i_Byte;
                2'd1:    word_q[15:8]  <= bus.i_Byte;
                default: word_q[23:16] <= bus.i_Byte;
              endcase
              idx_q <= idx_q + 2'd1;
            end
          end
        end
`endif

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ByteReady = rdy_q;
  assign bus.o_WrEn      = wren_q;
  assign bus.o_WrAddr    = wraddr_q;
  assign bus.o_WrData    = wrdata_q;
  assign bus.o_Busy      = busy_q;
  assign bus.o_Done      = done_q;
  assign bus.o_Overflow  = ovf_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign bus.o_Checksum  = chk_q;
  assign bus.o_ChkErr    = chkerr_q;
`endif

endmodule
